// File: rtl/if_id_queue.sv
// if_id_queue: decode-side receiver of the fetch valid/ack handshake.
// Buffers {instr, pc, br_pred} packets in an in-order circular FIFO and
// presents the oldest one to decode under valid/ready. A flush discards
// everything that is buffered.
// Optional build macro IFQ_BYPASS_EN: when the queue is empty and decode is
// ready, the incoming packet passes straight through with zero latency.
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    input  logic                     br_pred_i,
    output logic                     ack_o,
    output logic                     valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    output logic                     br_pred_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef logic [64:0] entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            not_empty;

    // Handshake decisions: accept, pop from storage, and the empty-queue bypass
    always_comb begin
        not_empty = (count_q != '0);
`ifdef IFQ_BYPASS_EN
        bypass    = !not_empty && valid_i && ready_i && !flush_i;
`else
        bypass    = 1'b0;
`endif
        ack_o     = bypass || (valid_i && !flush_i && (count_q < FULL_COUNT));
        push      = ack_o && !bypass;
        pop       = not_empty && ready_i && !flush_i;
    end

    // Head packet toward decode: a plain mux on the read pointer
    always_comb begin
        valid_o = not_empty || bypass;
        count_o = count_q;
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            {instr_o, pc_o, br_pred_o} = {instr_i, pc_i, br_pred_i};
        end else begin
            {instr_o, pc_o, br_pred_o} = mem_q[rd_ptr_q];
        end
`else
        {instr_o, pc_o, br_pred_o} = mem_q[rd_ptr_q];
`endif
    end

    // Next-state for storage, pointers and occupancy; flush only clears bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {instr_i, pc_i, br_pred_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios with literal
// expectations plus randomized fetch/decode traffic compared every cycle
// against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          flush_i;
    logic          valid_i;
    logic [31:0]   instr_i;
    logic [31:0]   pc_i;
    logic          br_pred_i;
    logic          ack_o;
    logic          valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic          br_pred_o;
    logic          ready_i;
    logic [CW-1:0] count_o;

    int            checks = 0;
    int            errors = 0;

    logic [64:0]   model_q [$];
    logic          m_ack = 1'b0;
    logic [31:0]   popped_pc [$];
    bit            record_pops = 1'b0;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn_i    (rstn_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .instr_i   (instr_i),
        .pc_i      (pc_i),
        .br_pred_i (br_pred_i),
        .ack_o     (ack_o),
        .valid_o   (valid_o),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .br_pred_o (br_pred_o),
        .ready_i   (ready_i),
        .count_o   (count_o)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs just after the active edge
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic br,
                                 input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        valid_i   = v;
        instr_i   = instr;
        pc_i      = pc;
        br_pred_i = br;
        ready_i   = rdy;
        flush_i   = fl;
    endtask

    // Reference model: an ordered queue of packets, checked every falling edge
    always @(negedge clk) begin : compare_proc
        int          n;
        logic        bypass;
        logic        exp_ack;
        logic        exp_valid;
        logic [64:0] head;
        n = model_q.size();
        if (!rstn_i) begin
            checkOutput("rst_valid", 32'(valid_o), 32'd0);
            checkOutput("rst_ack", 32'(ack_o), 32'd0);
            checkOutput("rst_count", 32'(count_o), 32'd0);
            checkOutput("rst_instr", instr_o, 32'd0);
            checkOutput("rst_pc", pc_o, 32'd0);
            model_q.delete();
            m_ack = 1'b0;
        end else begin
            bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
            bypass = (n == 0) && valid_i && ready_i && !flush_i;
`endif
            exp_ack   = valid_i && !flush_i && (n < DEPTH);
            exp_valid = (n != 0) || bypass;
            checkOutput("ack", 32'(ack_o), 32'(exp_ack));
            checkOutput("valid", 32'(valid_o), 32'(exp_valid));
            checkOutput("count", 32'(count_o), 32'(n));
            if (bypass) begin
                checkOutput("byp_instr", instr_o, instr_i);
                checkOutput("byp_pc", pc_o, pc_i);
                checkOutput("byp_br", 32'(br_pred_o), 32'(br_pred_i));
            end else if (n != 0) begin
                head = model_q[0];
                checkOutput("head_instr", instr_o, head[64:33]);
                checkOutput("head_pc", pc_o, head[32:1]);
                checkOutput("head_br", 32'(br_pred_o), 32'(head[0]));
            end
            if (record_pops && valid_o && ready_i && !flush_i) begin
                popped_pc.push_back(pc_o);
            end
            m_ack = exp_ack;
            if (flush_i) begin
                model_q.delete();
            end else if (!bypass) begin
                if (n != 0 && ready_i) begin
                    void'(model_q.pop_front());
                end
                if (exp_ack) begin
                    model_q.push_back({instr_i, pc_i, br_pred_i});
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin : stim_proc
        int          sent;
        int          cyc;
        logic        rdy;
        logic        have;
        logic [31:0] pinstr;
        logic [31:0] ppc;
        logic        pbr;
        logic        fl;

        rstn_i    = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        instr_i   = '0;
        pc_i      = '0;
        br_pred_i = 1'b0;
        ready_i   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_count", 32'(count_o), 32'd0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;

        // Single packet
        applyStimulus(1'b1, 32'h0050_0093, 32'h80, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_ack", 32'(ack_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_valid", 32'(valid_o), 32'd1);
        checkOutput("single_instr", instr_o, 32'h0050_0093);
        checkOutput("single_pc", pc_o, 32'h80);
        checkOutput("single_count", 32'(count_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_drained", 32'(count_o), 32'd0);

        // Fill to full, then a blocked fifth packet
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h13, 32'(4 * k), 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("fill_ack", 32'(ack_o), 32'd1);
        end
        applyStimulus(1'b1, 32'h13, 32'h10, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("full_count", 32'(count_o), 32'd4);
        checkOutput("full_ack", 32'(ack_o), 32'd0);
        checkOutput("full_head_pc", pc_o, 32'h0);
        applyStimulus(1'b1, 32'h13, 32'h10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("after_pop_count", 32'(count_o), 32'd3);
        checkOutput("after_pop_pc", pc_o, 32'h4);
        checkOutput("retry_ack", 32'(ack_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Wrap-around with ready toggling every cycle
        record_pops = 1'b1;
        popped_pc.delete();
        sent = 0;
        rdy  = 1'b0;
        cyc  = 0;
        while (popped_pc.size() < 10 && cyc < 100) begin
            applyStimulus(sent < 10, 32'h13, 32'h100 + 32'(4 * sent), 1'b0, rdy, 1'b0);
            @(negedge clk);
            #1;
            if (m_ack) sent++;
            rdy = !rdy;
            cyc++;
        end
        record_pops = 1'b0;
        checkOutput("wrap_pop_total", 32'(popped_pc.size()), 32'd10);
        for (int k = 0; k < 10 && k < popped_pc.size(); k++) begin
            checkOutput($sformatf("wrap_pc[%0d]", k), popped_pc[k], 32'h100 + 32'(4 * k));
        end

        // Flush with three entries buffered
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h13, 32'h200 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h13, 32'h20c, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_count_before", 32'(count_o), 32'd3);
        checkOutput("flush_ack", 32'(ack_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_count", 32'(count_o), 32'd0);
        checkOutput("flush_valid", 32'(valid_o), 32'd0);

        // Empty-queue pass-through (or its absence)
        applyStimulus(1'b1, 32'h13, 32'h40, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bypass_ack", 32'(ack_o), 32'd1);
`ifdef IFQ_BYPASS_EN
        checkOutput("bypass_valid", 32'(valid_o), 32'd1);
        checkOutput("bypass_pc", pc_o, 32'h40);
`else
        checkOutput("nobypass_valid", 32'(valid_o), 32'd0);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        checkOutput("bypass_count", 32'(count_o), 32'd0);
`else
        checkOutput("nobypass_count", 32'(count_o), 32'd1);
`endif

        // Randomized traffic with a fetch side that holds packets until acked
        have   = 1'b0;
        pinstr = '0;
        ppc    = '0;
        pbr    = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c == 900) begin
                @(posedge clk);
                #1;
                rstn_i  = 1'b0;
                valid_i = 1'b0;
                flush_i = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #1;
                rstn_i = 1'b1;
                have   = 1'b0;
            end
            if (!have && $urandom_range(0, 3) != 0) begin
                have   = 1'b1;
                pinstr = $urandom;
                ppc    = $urandom;
                pbr    = 1'($urandom_range(0, 1));
            end
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ((c % 300) < 150) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 3) != 0);
            applyStimulus(have, pinstr, ppc, pbr, rdy, fl);
            @(negedge clk);
            #1;
            if (m_ack || fl) have = 1'b0;
        end

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receiving end of the fetch-to-decode handshake (valid/ack) in the pipelined core. Sits at the input of the decode stage.
- Accepts fetched {instr, pc, br_pred} packets from the fetch stage and buffers them in a small in-order FIFO.
- Presents the oldest packet to the decoder under a valid/ready handshake, so short decode stalls do not block fetch.
- A flush from the pipeline control discards every buffered packet.

Parameters:
- DEPTH, 4, number of buffered packets; power of two, at least 2.

Ports:
- clk  input  1  core clock
- rstn_i  input  1  asynchronous active-low reset
- flush_i  input  1  discard all contents; held together with the fetch-stage flush
- valid_i  input  1  fetch packet valid; fetch holds the packet until ack_o
- instr_i  input  32  fetched instruction
- pc_i  input  32  pc of the fetched instruction
- br_pred_i  input  1  fetch predicted this instruction as a taken branch
- ack_o  output  1  packet accepted this cycle (single-cycle pulse per packet)
- valid_o  output  1  head packet valid toward decode
- instr_o  output  32  head instruction
- pc_o  output  32  head pc
- br_pred_o  output  1  head branch-prediction flag
- ready_i  input  1  decode consumes the head packet this cycle when valid_o is high
- count_o  output  $clog2(DEPTH)+1  number of buffered entries

Behaviour:
- Clock and reset: one clock, clk; reset rstn_i is asynchronous and active-low.
- Reset values: count, read pointer and write pointer are 0; all storage entries are 0; valid_o=0; instr_o=0, pc_o=0, br_pred_o=0; ack_o=0 (it is combinational and depends only on inputs and count).
- Storage: DEPTH x 65 bits, {instr, pc, br_pred}, in a circular buffer. The pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is held in a separate register.
- Accept rule: ack_o = valid_i && !flush_i && (count < DEPTH). push = ack_o.
- Full: ack_o is 0 even if decode pops in the same cycle. There is no same-cycle pop credit (timing decision). Fetch simply retries the next cycle.
- Pop rule: pop = valid_o && ready_i && !flush_i.
- Output: valid_o = (count != 0). The data outputs are the storage entry at the read pointer, mux only with no extra register.
- Latency: a packet acked in cycle N appears on valid_o in cycle N+1 at the earliest.
- Update per cycle:
  - push writes the entry at the write pointer and increments the write pointer.
  - pop increments the read pointer.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
- Flush: on the next edge, count=0 and both pointers=0. In the flush cycle, ack_o=0 and pop is ignored. Storage contents are left untouched but become invisible (valid_o=0).
- Flush while a fetch packet is pending: the packet is not acked. Fetch invalidates it itself.
- Ordering: packets leave strictly in arrival order, with no drop and no duplication.
- ready_i while valid_o=0: ignored.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- With the macro defined, when count==0 and valid_i && ready_i && !flush_i:
  - valid_o=1 and the data outputs equal instr_i/pc_i/br_pred_i combinationally.
  - ack_o=1, and nothing is written (no push, no count change).
  - Zero-cycle latency through an empty queue.
  - If ready_i=0 in that case, the normal push path applies.
- Without the macro: no combinational path from the valid_i/data inputs to the outputs. valid_o is derived from count only.

Test Plan:
- Reset: hold rstn_i=0 -> valid_o=0, ack_o=0, count_o=0, instr_o=0, pc_o=0.
- Single packet: send valid_i=1, instr_i=0x00500093, pc_i=0x80, br_pred_i=0, ready_i=0 -> ack_o=1 that cycle. Next cycle valid_o=1, instr_o=0x00500093, pc_o=0x80, count_o=1. Then raise ready_i=1 -> count_o=0 the following cycle.
- Fill (DEPTH=4): push pc 0x0,0x4,0x8,0xC with ready_i=0 -> count_o=4. A 5th valid_i (pc 0x10) gets ack_o=0, including with ready_i=1 in that cycle. pc_o=0x0 is popped, then pc 0x10 is acked the next cycle.
- Wrap-around: 10 packets (pc 0x100+4k) with ready_i toggling every cycle -> decode observes pc 0x100..0x124 in order, with no loss or duplication.
- Flush: with 3 entries buffered, assert flush_i together with valid_i and ready_i -> ack_o=0 that cycle. Next cycle count_o=0 and valid_o=0.
- Bypass (IFQ_BYPASS_EN): empty queue, valid_i=1, pc_i=0x40, ready_i=1 -> same cycle valid_o=1, pc_o=0x40, ack_o=1. Next cycle count_o=0. Without the macro, the same stimulus gives valid_o=0 in that cycle.
